serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor. It computes a WIDTH-bit sum or difference one bit per clock, using a single full-adder cell, behind a start/busy/done handshake. It replaces wide combinational adders in area-constrained datapaths where latency is acceptable. It reports carry/not-borrow and signed overflow.

---
 rtl/serial_addsub_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_addsub.sv | 89 ++++++++
 tb/tb_serial_addsub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder used as the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock through one full adder,
// with start/busy/done handshake and carry/overflow flags.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        sum       <= {fa_s, s_sr[WIDTH-1:1]};
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: arithmetic model plus directed vectors.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        carry_out;
    logic        overflow;

    logic        start16 = 1'b0;
    logic        sub16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        carry_out16;
    logic        overflow16;

    int passed = 0;
    int total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start16),
        .sub       (sub16),
        .a         (a16),
        .b         (b16),
        .busy      (busy16),
        .done      (done16),
        .sum       (sum16),
        .carry_out (carry_out16),
        .overflow  (overflow16)
    );

    // Arithmetic reference: plain integer add/sub, unsigned compare,
    // signed range test for overflow.
    function automatic logic [9:0] ref8(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic s);
        int ux, uy, sx, sy, r, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            co = (r > 255);
            sr = sx + sy;
        end
        ov = (sr > 127) || (sr < -128);
        return {r[7:0], co, ov};
    endfunction

    // Cycle-level expectation: WIDTH cycles busy after accept, then done.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [9:0] m_res = '0;
    logic [9:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = ref8(a, b, sub);
                m_left = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] got, exp;
            got = {busy, done, sum, carry_out, overflow};
            exp = {(m_left > 0), m_done, m_res};
            total++;
            if (got === exp) passed++;
            else $display("FAIL cycle8 t=%0t got=%h want=%h", $time, got, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    task automatic wait_done8(output int k);
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic go8(input logic [7:0] x, input logic [7:0] y,
                       input logic s, input string name,
                       input logic [9:0] exp);
        int k;
        @(negedge clk);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(k);
        chk({name, "_lat"}, k, 9);
        chk({name, "_res"}, {sum, carry_out, overflow}, exp);
    endtask

    initial begin
        int k;
        int ndone;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset", {busy, done, sum, carry_out, overflow}, 0);

        chk("model_pin", ref8(8'h80, 8'h01, 1'b1), {8'h7F, 1'b1, 1'b1});
        go8(8'h35, 8'h0A, 1'b0, "add35", {8'h3F, 1'b0, 1'b0});
        go8(8'hFF, 8'h01, 1'b0, "addFF", {8'h00, 1'b1, 1'b0});
        go8(8'h7F, 8'h01, 1'b0, "add7F", {8'h80, 1'b0, 1'b1});
        go8(8'h05, 8'h07, 1'b1, "sub05", {8'hFE, 1'b0, 1'b0});
        go8(8'h80, 8'h01, 1'b1, "sub80", {8'h7F, 1'b1, 1'b1});

        // start during RUN is ignored, then back-to-back from DONE
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(k);
        chk("ignore_done", done, 1'b1);
        chk("ignore_sum", sum, 8'h30);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(k);
        chk("b2b_lat", k, 9);
        chk("b2b_sum", sum, 8'h02);

        // abort by reset mid-run
        go8(8'h35, 8'h0A, 1'b0, "pre_rst", {8'h3F, 1'b0, 1'b0});
        @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out", {busy, done, sum, carry_out}, 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        go8(8'h01, 8'h02, 1'b0, "post_rst", {8'h03, 1'b0, 1'b0});

        // 16-bit instance
        @(negedge clk);
        a16 = 16'h8000; b16 = 16'h0001; sub16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        k = 1;
        while (!done16 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("w16_lat", k, 17);
        chk("w16_res", {sum16, carry_out16, overflow16},
            {16'h7FFF, 1'b1, 1'b1});

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
